// File: rtl/multicycle_adder_pkg.sv
// Shared types and configuration helpers for multicycle_adder.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Slices must tile the word exactly and hold a distinct MSB below the ripple.
  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 2) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple slice; also exposes the carry into its MSB.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] w_low;

  // Low bits first; their top bit is the carry feeding the slice MSB.
  always_comb begin
    w_low = {1'b0, a[CHUNK-2:0]} + {1'b0, b[CHUNK-2:0]} + {{(CHUNK-1){1'b0}}, cin};
    c_msb = w_low[CHUNK-1];
    sum   = {a[CHUNK-1] ^ b[CHUNK-1] ^ w_low[CHUNK-1], w_low[CHUNK-2:0]};
    cout  = (a[CHUNK-1] & b[CHUNK-1]) | (w_low[CHUNK-1] & (a[CHUNK-1] ^ b[CHUNK-1]));
  end

endmodule

// File: rtl/multicycle_adder.sv
// WIDTH-bit add/subtract evaluated one CHUNK slice per cycle with valid/ready on both sides.
// Optional signed saturation is compiled in with MULTICYCLE_ADDER_SAT_EN.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK, CHUNK >= 2");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic               r_out_valid;
  logic               w_accept;
  logic               w_last;
  logic [CHUNK-1:0]   w_a_slice;
  logic [CHUNK-1:0]   w_b_slice;
  logic [CHUNK-1:0]   w_slice_sum;
  logic               w_cout;
  logic               w_cmsb;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_sum_next;
  logic [WIDTH-1:0]   w_sum_final;

  assign w_a_slice = r_a[r_cnt*CHUNK +: CHUNK];
  assign w_b_slice = r_b[r_cnt*CHUNK +: CHUNK];
  assign w_last    = (r_cnt == CNT_W'(NCHUNK - 1));
  assign w_ovf     = w_cmsb ^ w_cout;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (w_a_slice),
    .b     (w_b_slice),
    .cin   (r_carry),
    .sum   (w_slice_sum),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and the handshake ready; a DONE slot can hand straight to RUN.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
        else          w_state_next = IDLE;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
        else        w_state_next = RUN;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready && in_valid) w_state_next = RUN;
        else if (out_ready)        w_state_next = IDLE;
        else                       w_state_next = DONE;
      end
      default: begin
        w_state_next = IDLE;
        in_ready     = 1'b0;
      end
    endcase
  end

  assign w_accept = in_valid & in_ready;

  // Merge the current slice into the result word, saturating on the final slice if enabled.
  always_comb begin
    w_sum_next = r_sum;
    w_sum_next[r_cnt*CHUNK +: CHUNK] = w_slice_sum;
`ifdef MULTICYCLE_ADDER_SAT_EN
    if (w_ovf) begin
      if (r_a[WIDTH-1]) w_sum_final = {1'b1, {(WIDTH-1){1'b0}}};
      else              w_sum_final = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_sum_final = w_sum_next;
    end
`else
    w_sum_final = w_sum_next;
`endif
  end

  // Operand capture, slice iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_a         <= a;
      r_b         <= sub ? ~b : b;
      r_carry     <= cin ^ sub;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == RUN) begin
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum       <= w_sum_final;
        r_cout      <= w_cout;
        r_ovf       <= w_ovf;
        r_out_valid <= 1'b1;
      end else begin
        r_sum <= w_sum_next;
      end
    end else if (r_state == DONE && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair one CHUNK-bit slice per clock, carrying between slices through a registered carry. It replaces the fixed 8-bit combinational ripple adder for wide datapaths where a full-width carry chain would not close timing. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides, and adds subtract mode, signed-overflow detection and optional saturation.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of CHUNK.
- CHUNK, 8: bits added per cycle; NCHUNK = WIDTH/CHUNK cycles per operation.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0 computes a+b+cin; 1 computes a-b-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Values in reset: in_ready=1 in IDLE; out_valid=0; sum=0; cout=0; ovf=0; slice counter=0.
- IDLE: in_ready=1. When in_valid&in_ready, the block:
  - latches a;
  - latches b, inverted when sub=1;
  - sets carry = cin ^ sub;
  - clears the slice counter;
  - moves to RUN.
- RUN:
  - Each cycle, slice k adds a[k*CHUNK +: CHUNK], the latched b slice and the carry register.
  - It writes sum[k*CHUNK +: CHUNK], updates carry and increments k.
  - After slice NCHUNK-1:
    - cout = final carry;
    - ovf = carry into MSB XOR carry out of MSB;
    - state moves to DONE.
- DONE: out_valid=1; sum, cout and ovf are held stable until out_ready.
  - out_ready=1 and in_valid=0: move to IDLE and drop out_valid.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). A new operand pair accepted in DONE goes directly to RUN, with no IDLE bubble.
- in_ready=0 in RUN. Inputs are ignored there.
- Arithmetic is modulo 2^WIDTH; the result wraps unless saturation is compiled in.
- sum contents are meaningful only while out_valid=1.
- Reset asserted at any time aborts the operation and returns all outputs to their reset values immediately. The partial result is discarded.

## Timing
- Operands are accepted at rising edge T.
- out_valid rises after edge T+NCHUNK; latency is NCHUNK cycles.
- Peak throughput is one result per NCHUNK+1 cycles when the consumer keeps out_ready high. The extra cycle is the DONE handshake, overlapped with the next accept.
- The critical path is one CHUNK-bit ripple chain plus the carry register.
- in_ready is combinational from state and out_ready. All other outputs are registered.

## Configuration
- MULTICYCLE_ADDER_SAT_EN defined: when ovf=1, sum is forced to signed saturation.
  - Operand sign 0 (after the b inversion): 0x7F..F.
  - Operand sign 1: 0x80..0.
  - ovf is still reported; cout is unchanged.
- Undefined: sum wraps, and ovf is a status flag only.

## Structure
- Package multicycle_adder_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the NCHUNK derivation;
  - the elaboration check that WIDTH % CHUNK == 0.
- Sub-module chunk_adder is a combinational CHUNK-bit ripple adder. Its outputs are:
  - slice sum;
  - carry out;
  - carry into the slice MSB, used for ovf on the last slice.
- The top level holds the FSM, the slice counter, the carry register and the operand/result registers.

## Test plan
All scenarios use WIDTH=32, CHUNK=8.
- Basic add: a=0x000000FF, b=1, cin=0, sub=0 -> sum=0x00000100, cout=0, ovf=0. out_valid rises exactly 4 cycles after accept.
- Unsigned wrap: a=0xFFFFFFFF, b=1, cin=0 -> sum=0, cout=1, ovf=0. Checks the carry ripple across all 4 slices.
- Signed overflow: a=0x7FFFFFFF, b=1 -> ovf=1. Without the macro, sum=0x80000000; with MULTICYCLE_ADDER_SAT_EN, sum=0x7FFFFFFF.
- Subtract:
  - 5-7 with cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - 7-5 -> sum=2, cout=1.
  - 7-5 with cin=1 -> sum=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE -> sum, cout, ovf and out_valid remain stable, and in_ready=0.
  - Then raise out_ready and in_valid together -> the new pair is accepted that cycle, and the next result arrives 4 cycles later.
- Reset mid-operation: pull rst_n low during slice 2 -> out_valid=0, sum=0 and in_ready=1 immediately. After release, a fresh add completes correctly.
